map_table: RTL and testbench
============================

Name: map_table

Overview:
- Rename map table; sits directly upstream of the free list in dispatch.
- Consumes `free_reg`/`empty` from the free list.
- Produces T_new/T_old per renamed destination; T_old travels via the ROB and returns to the free list at retire.
- Tracks per-architectural-register ready bits from CDB broadcasts.
- Holds one branch checkpoint for single-cycle rollback.

Parameters:
- NUM_GEN_REG, 32, architectural registers; reg 0 is never renamed.
- NUM_PHYS_REG, 64, physical registers.
- AW = $clog2(NUM_GEN_REG) and PW = $clog2(NUM_PHYS_REG) are derived localparams, not overridable.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-low: state reset on posedge while reset==0.
- dispatch_en  in  1  instruction dispatching this cycle.
- rd_valid  in  1  instruction writes a destination.
- rd_arch  in  AW  destination architectural reg.
- rs1_arch  in  AW  source 1 architectural reg.
- rs2_arch  in  AW  source 2 architectural reg.
- free_reg  in  PW  head of free list.
- free_empty  in  1  free list empty.
- cdb_en  in  1  CDB broadcast valid.
- cdb_tag  in  PW  completing physical reg.
- checkpoint_en  in  1  snapshot state this cycle.
- rollback_en  in  1  restore snapshot this cycle.
- rs1_tag  out  PW  physical mapping of rs1.
- rs1_ready  out  1  rs1 value available.
- rs2_tag  out  PW  physical mapping of rs2.
- rs2_ready  out  1  rs2 value available.
- T_new  out  PW  new mapping (= free_reg).
- T_old  out  PW  previous mapping of rd_arch.
- rename_fire  out  1  rename committed this cycle; drives free-list dispatch_en.
- stall  out  1  dispatch blocked (dispatch_en & rd_valid & rd_arch!=0 & free_empty).
- ckpt_valid  out  1  snapshot held.

Behaviour:
- Reset (reset==0 at posedge):
  - map[i]=i and ready[i]=1 for all i.
  - Snapshot cleared, ckpt_valid=0.
  - Reset overrides every other input.
- Source lookup and outputs are combinational and reflect the pre-update table.
  - Same-instruction rd==rs returns the old mapping.
  - T_old = map[rd_arch]; T_new = free_reg.
- rename_fire = dispatch_en & rd_valid & (rd_arch!=0) & !free_empty & !rollback_en.
- On posedge with rename_fire:
  - map[rd_arch] <= free_reg.
  - ready[rd_arch] <= 0.
- dispatch_en with rd_valid=0 or rd_arch==0: sources still looked up; no state change; no stall.
- CDB (cdb_en): every i with map[i]==cdb_tag gets ready[i] <= 1.
  - Same-cycle rename of that entry wins: entry ends with the new tag, not ready.
- Snapshot ready bits also track CDB while ckpt_valid, so broadcasts after the checkpoint survive rollback.
- checkpoint_en (and !rollback_en):
  - Snapshot <= post-update state of this cycle, including this cycle's rename and CDB.
  - ckpt_valid <= 1.
  - A new checkpoint overwrites the old one.
- rollback_en with ckpt_valid:
  - map and ready <= snapshot, with this cycle's CDB applied to the restored ready bits.
  - ckpt_valid <= 0.
  - Dispatch and checkpoint are ignored that cycle; rename_fire=0.
- rollback_en without ckpt_valid: no state change except normal CDB; rename still suppressed.
- Priority, high to low: reset, rollback, rename/checkpoint, CDB.
- Register 0: map[0]=0 and ready[0]=1 permanently.

Optional Feature:
- Macro MAP_TABLE_CDB_BYPASS_EN.
  - Defined: rsX_ready is also forced to 1 when cdb_en & cdb_tag==rsX_tag in the same cycle (combinational forward).
  - Undefined: a CDB-set ready bit is visible on rsX_ready only from the next cycle.
- State updates are identical either way.

Test Plan:
- Hold reset=0 one cycle, then release → for all i, lookup of i gives tag i, ready=1; ckpt_valid=0.
- Dispatch rd=3, rs1=3, free_reg=40 → same cycle rs1_tag=3, T_old=3, T_new=40, rename_fire=1; next cycle lookup 3 → tag 40, ready=0.
- After the above, cdb_en with tag 40 → next cycle lookup 3 → ready=1.
  - With the macro defined, rs1_ready=1 already in the CDB cycle.
- free_empty=1, dispatch rd=5 → stall=1, rename_fire=0, map[5] unchanged.
  - Same stimulus with rd=0 → stall=0.
- Checkpoint, rename rd=7→41, broadcast tag 3, then rollback:
  - Result: map[7]=7, ready[3] reflects the CDB, ckpt_valid=0.
  - A dispatch issued in the rollback cycle is dropped (rename_fire=0).
- Assert reset=0 mid-sequence while dispatch_en=1 and checkpoint_en=1 → full reset state, ckpt_valid=0, no rename applied.

Source files
------------

// File: rtl/map_table.sv
// map_table: rename map table with per-register ready bits and a single
// branch checkpoint. Sits upstream of the free list in dispatch: consumes
// free_reg/free_empty, produces T_new/T_old and source tags/ready bits.
// Optional build macro: MAP_TABLE_CDB_BYPASS_EN forwards a same-cycle CDB
// broadcast onto rs1_ready/rs2_ready (state updates are identical either way).
module map_table #(
  parameter  int NUM_GEN_REG  = 32,
  parameter  int NUM_PHYS_REG = 64,
  localparam int AW           = $clog2(NUM_GEN_REG),
  localparam int PW           = $clog2(NUM_PHYS_REG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dispatch_en,
  input  logic          rd_valid,
  input  logic [AW-1:0] rd_arch,
  input  logic [AW-1:0] rs1_arch,
  input  logic [AW-1:0] rs2_arch,
  input  logic [PW-1:0] free_reg,
  input  logic          free_empty,
  input  logic          cdb_en,
  input  logic [PW-1:0] cdb_tag,
  input  logic          checkpoint_en,
  input  logic          rollback_en,
  output logic [PW-1:0] rs1_tag,
  output logic          rs1_ready,
  output logic [PW-1:0] rs2_tag,
  output logic          rs2_ready,
  output logic [PW-1:0] T_new,
  output logic [PW-1:0] T_old,
  output logic          rename_fire,
  output logic          stall,
  output logic          ckpt_valid
);

  // Live table and its snapshot
  logic [PW-1:0]          map_tbl  [NUM_GEN_REG];
  logic [NUM_GEN_REG-1:0] rdy_tbl;
  logic [PW-1:0]          snap_map [NUM_GEN_REG];
  logic [NUM_GEN_REG-1:0] snap_rdy;

  // Next-state values
  logic [PW-1:0]          map_nxt  [NUM_GEN_REG];
  logic [NUM_GEN_REG-1:0] rdy_nxt;
  logic [NUM_GEN_REG-1:0] snap_rdy_nxt;

  logic rd_writes;
  logic do_rollback;
  logic do_ckpt;

  assign rd_writes   = dispatch_en & rd_valid & (rd_arch != '0);
  assign do_rollback = rollback_en & ckpt_valid;
  // A rollback request always wins over a checkpoint, even with no snapshot held.
  assign do_ckpt     = checkpoint_en & ~rollback_en;

  assign stall       = rd_writes & free_empty;
  assign rename_fire = rd_writes & ~free_empty & ~rollback_en;

  // Lookups read the pre-update table, so rd==rs sees the old mapping.
  assign T_new   = free_reg;
  assign T_old   = map_tbl[rd_arch];
  assign rs1_tag = map_tbl[rs1_arch];
  assign rs2_tag = map_tbl[rs2_arch];

`ifdef MAP_TABLE_CDB_BYPASS_EN
  assign rs1_ready = rdy_tbl[rs1_arch] | (cdb_en & (cdb_tag == rs1_tag));
  assign rs2_ready = rdy_tbl[rs2_arch] | (cdb_en & (cdb_tag == rs2_tag));
`else
  assign rs1_ready = rdy_tbl[rs1_arch];
  assign rs2_ready = rdy_tbl[rs2_arch];
`endif

  // Next-state: CDB wakeup, then rename or rollback on top, reg 0 pinned last.
  always_comb begin
    for (int i = 0; i < NUM_GEN_REG; i++) begin
      map_nxt[i]      = map_tbl[i];
      rdy_nxt[i]      = rdy_tbl[i] | (cdb_en & (map_tbl[i] == cdb_tag));
      // Snapshot keeps listening to the CDB so post-checkpoint wakeups survive rollback.
      snap_rdy_nxt[i] = snap_rdy[i] | (ckpt_valid & cdb_en & (snap_map[i] == cdb_tag));
    end
    if (do_rollback) begin
      for (int i = 0; i < NUM_GEN_REG; i++) begin
        map_nxt[i] = snap_map[i];
        rdy_nxt[i] = snap_rdy_nxt[i];
      end
    end else if (rename_fire) begin
      // Rename overrides a same-cycle wakeup of the old tag.
      map_nxt[rd_arch] = free_reg;
      rdy_nxt[rd_arch] = 1'b0;
    end
    map_nxt[0] = '0;
    rdy_nxt[0] = 1'b1;
  end

  // State update: identity map on reset, otherwise commit next-state and snapshot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_GEN_REG; i++) begin
        map_tbl[i]  <= PW'(i);
        snap_map[i] <= PW'(i);
      end
      rdy_tbl    <= '1;
      snap_rdy   <= '1;
      ckpt_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_GEN_REG; i++) begin
        map_tbl[i] <= map_nxt[i];
      end
      rdy_tbl <= rdy_nxt;
      if (do_ckpt) begin
        for (int i = 0; i < NUM_GEN_REG; i++) begin
          snap_map[i] <= map_nxt[i];
        end
        snap_rdy   <= rdy_nxt;
        ckpt_valid <= 1'b1;
      end else begin
        snap_rdy <= snap_rdy_nxt;
        if (do_rollback) begin
          ckpt_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_map_table.sv
// tb_map_table: scenario-per-task bench for map_table. Expected source
// lookups are queued when stimulus is applied and popped when sampled.
module tb_map_table;
  localparam int AW = 5;
  localparam int PW = 6;
`ifdef MAP_TABLE_CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          dispatch_en, rd_valid, free_empty, cdb_en, checkpoint_en, rollback_en;
  logic [AW-1:0] rd_arch, rs1_arch, rs2_arch;
  logic [PW-1:0] free_reg, cdb_tag;
  logic [PW-1:0] rs1_tag, rs2_tag, T_new, T_old;
  logic          rs1_ready, rs2_ready, rename_fire, stall, ckpt_valid;

  typedef struct {
    logic [PW-1:0] tag;
    logic          rdy;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  map_table dut (
    .clock(clock), .reset(reset), .dispatch_en(dispatch_en), .rd_valid(rd_valid),
    .rd_arch(rd_arch), .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .free_reg(free_reg),
    .free_empty(free_empty), .cdb_en(cdb_en), .cdb_tag(cdb_tag),
    .checkpoint_en(checkpoint_en), .rollback_en(rollback_en),
    .rs1_tag(rs1_tag), .rs1_ready(rs1_ready), .rs2_tag(rs2_tag), .rs2_ready(rs2_ready),
    .T_new(T_new), .T_old(T_old), .rename_fire(rename_fire), .stall(stall),
    .ckpt_valid(ckpt_valid)
  );

  task automatic idle();
    reset = 1'b1; dispatch_en = 1'b0; rd_valid = 1'b0; rd_arch = '0;
    rs1_arch = '0; rs2_arch = '0; free_reg = '0; free_empty = 1'b0;
    cdb_en = 1'b0; cdb_tag = '0; checkpoint_en = 1'b0; rollback_en = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  // Queue lookups of a and b, then compare both ports against the queue.
  task automatic lookup_pair(input string nm, input int a, input int ta, input logic ra,
                             input int b, input int tb, input logic rb);
    exp_t e;
    rs1_arch = AW'(a); rs2_arch = AW'(b);
    sb.push_back('{tag: PW'(ta), rdy: ra});
    sb.push_back('{tag: PW'(tb), rdy: rb});
    #1;
    e = sb.pop_front(); total++;
    if (rs1_tag !== e.tag || rs1_ready !== e.rdy) begin
      bad++;
      $display("FAIL %s rs1[%0d] got tag=%0d rdy=%b want tag=%0d rdy=%b", nm, a, rs1_tag, rs1_ready, e.tag, e.rdy);
    end
    e = sb.pop_front(); total++;
    if (rs2_tag !== e.tag || rs2_ready !== e.rdy) begin
      bad++;
      $display("FAIL %s rs2[%0d] got tag=%0d rdy=%b want tag=%0d rdy=%b", nm, b, rs2_tag, rs2_ready, e.tag, e.rdy);
    end
  endtask

  task automatic test_reset();
    idle(); reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    total++;
    if (ckpt_valid !== 1'b0) begin bad++; $display("FAIL reset_ckpt got=%b want=0", ckpt_valid); end
    for (int i = 0; i < 32; i++) lookup_pair("reset_map", i, i, 1'b1, 31 - i, 31 - i, 1'b1);
    next_cycle();
  endtask

  task automatic test_rename();
    idle();
    dispatch_en = 1'b1; rd_valid = 1'b1; rd_arch = 5'd3; free_reg = 6'd40;
    lookup_pair("rename_same", 3, 3, 1'b1, 3, 3, 1'b1);
    total++;
    if (T_old !== 6'd3 || T_new !== 6'd40) begin
      bad++; $display("FAIL rename_T got old=%0d new=%0d want old=3 new=40", T_old, T_new);
    end
    total++;
    if (rename_fire !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL rename_fire got fire=%b stall=%b want fire=1 stall=0", rename_fire, stall);
    end
    next_cycle(); idle();
    lookup_pair("rename_after", 3, 40, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_cdb();
    idle();
    cdb_en = 1'b1; cdb_tag = 6'd40;
    lookup_pair("cdb_same_cycle", 3, 40, BYP, 4, 4, 1'b1);
    next_cycle(); idle();
    lookup_pair("cdb_after", 3, 40, 1'b1, 4, 4, 1'b1);
  endtask

  task automatic test_stall();
    idle();
    dispatch_en = 1'b1; rd_valid = 1'b1; rd_arch = 5'd5; free_reg = 6'd42; free_empty = 1'b1;
    #1; total++;
    if (stall !== 1'b1 || rename_fire !== 1'b0) begin
      bad++; $display("FAIL stall_rd5 got stall=%b fire=%b want stall=1 fire=0", stall, rename_fire);
    end
    rd_arch = 5'd0;
    #1; total++;
    if (stall !== 1'b0 || rename_fire !== 1'b0) begin
      bad++; $display("FAIL stall_rd0 got stall=%b fire=%b want stall=0 fire=0", stall, rename_fire);
    end
    next_cycle(); idle();
    lookup_pair("stall_nochange", 5, 5, 1'b1, 0, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    idle();
    dispatch_en = 1'b1; rd_valid = 1'b1; rd_arch = 5'd3; free_reg = 6'd47;
    lookup_pair("b2b_first", 3, 40, 1'b1, 5, 5, 1'b1);
    next_cycle();
    free_reg = 6'd48;
    lookup_pair("b2b_second", 3, 47, 1'b0, 5, 5, 1'b1);
    total++;
    if (T_old !== 6'd47 || rename_fire !== 1'b1) begin
      bad++; $display("FAIL b2b_T_old got old=%0d fire=%b want old=47 fire=1", T_old, rename_fire);
    end
    next_cycle();
    // Rename of rd=20 collides with a wakeup of its old tag 20.
    rd_arch = 5'd20; free_reg = 6'd50; cdb_en = 1'b1; cdb_tag = 6'd20;
    next_cycle(); idle();
    lookup_pair("b2b_rename_wins", 3, 48, 1'b0, 20, 50, 1'b0);
  endtask

  task automatic test_rollback();
    idle();
    checkpoint_en = 1'b1; dispatch_en = 1'b1; rd_valid = 1'b1; rd_arch = 5'd9; free_reg = 6'd43;
    next_cycle(); idle();
    total++;
    if (ckpt_valid !== 1'b1) begin bad++; $display("FAIL ckpt_set got=%b want=1", ckpt_valid); end
    dispatch_en = 1'b1; rd_valid = 1'b1; rd_arch = 5'd7; free_reg = 6'd41;
    next_cycle(); idle();
    cdb_en = 1'b1; cdb_tag = 6'd43;
    next_cycle(); idle();
    lookup_pair("rb_before", 7, 41, 1'b0, 9, 43, 1'b1);
    rollback_en = 1'b1; dispatch_en = 1'b1; rd_valid = 1'b1; rd_arch = 5'd11; free_reg = 6'd44;
    #1; total++;
    if (rename_fire !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL rb_drop got fire=%b stall=%b want fire=0 stall=0", rename_fire, stall);
    end
    next_cycle(); idle();
    total++;
    if (ckpt_valid !== 1'b0) begin bad++; $display("FAIL rb_ckpt_clear got=%b want=0", ckpt_valid); end
    lookup_pair("rb_restore_a", 7, 7, 1'b1, 9, 43, 1'b1);
    lookup_pair("rb_restore_b", 11, 11, 1'b1, 3, 48, 1'b0);
    // Checkpoint with rename, then rollback while the new tag broadcasts.
    checkpoint_en = 1'b1; dispatch_en = 1'b1; rd_valid = 1'b1; rd_arch = 5'd12; free_reg = 6'd45;
    next_cycle(); idle();
    rollback_en = 1'b1; cdb_en = 1'b1; cdb_tag = 6'd45;
    next_cycle(); idle();
    lookup_pair("rb_cdb_restore", 12, 45, 1'b1, 20, 50, 1'b0);
    // Rollback with no snapshot held still blocks rename.
    rollback_en = 1'b1; dispatch_en = 1'b1; rd_valid = 1'b1; rd_arch = 5'd13; free_reg = 6'd46;
    #1; total++;
    if (rename_fire !== 1'b0 || ckpt_valid !== 1'b0) begin
      bad++; $display("FAIL rb_nockpt got fire=%b ckpt=%b want fire=0 ckpt=0", rename_fire, ckpt_valid);
    end
    next_cycle(); idle();
    lookup_pair("rb_nockpt_map", 13, 13, 1'b1, 12, 45, 1'b1);
  endtask

  task automatic test_reset_mid();
    idle();
    reset = 1'b0; dispatch_en = 1'b1; rd_valid = 1'b1; rd_arch = 5'd14; free_reg = 6'd46;
    checkpoint_en = 1'b1; cdb_en = 1'b1; cdb_tag = 6'd48;
    next_cycle(); idle();
    total++;
    if (ckpt_valid !== 1'b0) begin bad++; $display("FAIL rstmid_ckpt got=%b want=0", ckpt_valid); end
    lookup_pair("rstmid_a", 14, 14, 1'b1, 3, 3, 1'b1);
    lookup_pair("rstmid_b", 12, 12, 1'b1, 20, 20, 1'b1);
  endtask

  initial begin
    idle();
    test_reset();
    test_rename();
    test_cdb();
    test_stall();
    test_back_to_back();
    test_rollback();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
